// File: rtl/oam_dma_bus_arbiter_pkg.sv
// Shared constants, state/select encodings and the echo-RAM page helper for the
// OAM DMA bus arbiter.
package oam_dma_bus_arbiter_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_BASE    = 16'hFF80;
    localparam int          DMA_LEN      = 160;
    localparam logic [7:0]  LAST_INDEX   = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        DMA_IDLE,
        DMA_START,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    typedef enum logic [1:0] {
        RSEL_NONE,
        RSEL_MEM,
        RSEL_DMAREG,
        RSEL_BLOCKED
    } rsel_t;

    // Pages E0..FF alias work RAM at C0..DF.
    function automatic logic [7:0] effective_page(input logic [7:0] src);
        return (src >= 8'hE0) ? src - 8'h20 : src;
    endfunction

endpackage

// File: rtl/oam_dma_bus_arbiter_engine.sv
// OAM DMA engine: sequencer, byte index, source register and OAM write port.
// Requests the memory port in READ and waits there until port_free grants it.
module oam_dma_engine
    import oam_dma_bus_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_src,
    input  logic        port_free,
    input  logic [7:0]  mem_data,
    output logic        read_req,
    output logic [15:0] read_addr,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        busy,
    output logic [7:0]  dma_src
);

    dma_state_t state, next_state;
    logic [7:0] index;
    logic [7:0] src;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DMA_IDLE;
            index <= 8'h00;
            src   <= 8'h00;
        end else begin
            state <= next_state;
            if (start)
                src <= start_src;
            if (state == DMA_START)
                index <= 8'h00;
            else if (state == DMA_WRITE && !start)
                index <= index + 8'h01;
        end
    end

    // NOTE: next_state gets its default first so no path through the block infers a latch.
    always_comb begin
        next_state = state;
        if (start) begin
            next_state = DMA_START;
        end else begin
            case (state)
                DMA_IDLE:  next_state = DMA_IDLE;
                DMA_START: next_state = DMA_READ;
                DMA_READ:  next_state = port_free ? DMA_WRITE : DMA_READ;
                DMA_WRITE: next_state = (index < LAST_INDEX) ? DMA_READ : DMA_IDLE;
                default:   next_state = DMA_IDLE;
            endcase
        end
    end

    assign read_req  = (state == DMA_READ);
    assign read_addr = {effective_page(src), index};
    // A restart landing on WRITE discards the in-flight byte.
    assign oam_we    = (state == DMA_WRITE) && !start;
    assign oam_addr  = index;
    assign oam_data  = mem_data;
    assign busy      = (state != DMA_IDLE);
    assign dma_src   = src;

endmodule

// File: rtl/oam_dma_bus_arbiter.sv
// Arbiter for the shared external memory port: CPU passthrough, FF46 register
// decode, HRAM-only access during DMA, and the registered CPU read-return mux.
module oam_dma_bus_arbiter
    import oam_dma_bus_arbiter_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    input  logic        iCpuWe,
    input  logic        iCpuReadRequest,
    output logic [7:0]  oCpuData,
    output logic [15:0] oMemAddr,
    output logic [7:0]  oMemData,
    output logic        oMemWe,
    output logic        oMemReadRequest,
    input  logic [7:0]  iMemData,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData,
    output logic        oOamWe,
    output logic        oDmaBusy
);

    logic        cpu_wr, cpu_rd;
    logic        is_dma_reg, is_hram;
    logic        cpu_to_mem, cpu_mem_wr, cpu_mem_rd;
    logic        dma_start, port_free;
    logic        dma_read_req;
    logic [15:0] dma_read_addr;
    logic [7:0]  dma_src;
    rsel_t       rsel;

    // A simultaneous write wins; the read is ignored.
    assign cpu_wr     = iCpuWe;
    assign cpu_rd     = iCpuReadRequest && !iCpuWe;
    assign is_dma_reg = (iCpuAddr == DMA_REG_ADDR);
    assign is_hram    = (iCpuAddr >= HRAM_BASE);

    assign dma_start  = cpu_wr && is_dma_reg;
    assign cpu_to_mem = !is_dma_reg && (!oDmaBusy || is_hram);
    assign cpu_mem_wr = cpu_wr && cpu_to_mem;
    assign cpu_mem_rd = cpu_rd && cpu_to_mem;
    assign port_free  = !(cpu_mem_wr || cpu_mem_rd);

    oam_dma_engine u_engine (
        .clk       (iClock),
        .rst       (iReset),
        .start     (dma_start),
        .start_src (iCpuData),
        .port_free (port_free),
        .mem_data  (iMemData),
        .read_req  (dma_read_req),
        .read_addr (dma_read_addr),
        .oam_we    (oOamWe),
        .oam_addr  (oOamAddr),
        .oam_data  (oOamData),
        .busy      (oDmaBusy),
        .dma_src   (dma_src)
    );

    always_comb begin
        oMemAddr        = iCpuAddr;
        oMemData        = iCpuData;
        oMemWe          = cpu_mem_wr;
        oMemReadRequest = cpu_mem_rd;
        if (dma_read_req && port_free) begin
            oMemAddr        = dma_read_addr;
            oMemWe          = 1'b0;
            oMemReadRequest = 1'b1;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset)
            rsel <= RSEL_NONE;
        else if (cpu_rd)
            rsel <= is_dma_reg ? RSEL_DMAREG : (cpu_to_mem ? RSEL_MEM : RSEL_BLOCKED);
        else
            rsel <= RSEL_NONE;
    end

    always_comb begin
        case (rsel)
            RSEL_MEM:    oCpuData = iMemData;
            RSEL_DMAREG: oCpuData = dma_src;
            default:     oCpuData = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Directed bench for oam_dma_bus_arbiter: passthrough, full DMA, blocking,
// collisions, restart, echo mirroring and mid-transfer reset.
module tb_oam_dma_bus_arbiter;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [15:0] iCpuAddr;
    logic [7:0]  iCpuData;
    logic        iCpuWe;
    logic        iCpuReadRequest;
    logic [7:0]  oCpuData;
    logic [15:0] oMemAddr;
    logic [7:0]  oMemData;
    logic        oMemWe;
    logic        oMemReadRequest;
    logic [7:0]  iMemData = 8'h00;
    logic [7:0]  oOamAddr;
    logic [7:0]  oOamData;
    logic        oOamWe;
    logic        oDmaBusy;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [7:0] oam [0:159];

    oam_dma_bus_arbiter dut (
        .iClock          (iClock),
        .iReset          (iReset),
        .iCpuAddr        (iCpuAddr),
        .iCpuData        (iCpuData),
        .iCpuWe          (iCpuWe),
        .iCpuReadRequest (iCpuReadRequest),
        .oCpuData        (oCpuData),
        .oMemAddr        (oMemAddr),
        .oMemData        (oMemData),
        .oMemWe          (oMemWe),
        .oMemReadRequest (oMemReadRequest),
        .iMemData        (iMemData),
        .oOamAddr        (oOamAddr),
        .oOamData        (oOamData),
        .oOamWe          (oOamWe),
        .oDmaBusy        (oDmaBusy)
    );

    always #5 iClock = ~iClock;

    // Memory returns the low address byte for page C0; other pages are xor-tagged.
    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC0;
    endfunction

    always @(posedge iClock) begin
        if (oMemReadRequest)
            iMemData <= mem_model(oMemAddr);
        if (oOamWe)
            oam[oOamAddr] <= oOamData;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic cpu_idle();
        iCpuAddr        = 16'h0000;
        iCpuData        = 8'h00;
        iCpuWe          = 1'b0;
        iCpuReadRequest = 1'b0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        iCpuAddr = a;
        iCpuData = d;
        iCpuWe   = 1'b1;
        step();
        cpu_idle();
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (oDmaBusy && n < 2000) begin
            n++;
            step();
        end
    endtask

    task automatic check_oam(input int lo, input int hi, input logic [7:0] tag_xor);
        for (int i = lo; i <= hi; i++)
            check($sformatf("oam[%0d]", i), oam[i], 8'(i) ^ tag_xor);
    endtask

    task automatic check_dma_reg(input logic [7:0] exp);
        iCpuAddr        = 16'hFF46;
        iCpuReadRequest = 1'b1;
        #1;
        check("ff46_rd_no_strobe", oMemReadRequest, 1'b0);
        step();
        cpu_idle();
        check("ff46_rd_data", oCpuData, exp);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 160; i++) oam[i] = 8'h00;
        cpu_idle();
        iReset = 1'b1;
        repeat (3) @(posedge iClock);
        #1;
        check("rst_busy", oDmaBusy, 1'b0);
        check("rst_oam_we", oOamWe, 1'b0);
        check("rst_mem_we", oMemWe, 1'b0);
        check("rst_mem_rd", oMemReadRequest, 1'b0);
        check("rst_cpu_data", oCpuData, 8'hFF);
        iReset = 1'b0;
        step();
        check_dma_reg(8'h00);
        step();
        check("no_pending_ff", oCpuData, 8'hFF);

        // 1) Idle passthrough
        iCpuAddr        = 16'hC123;
        iCpuReadRequest = 1'b1;
        #1;
        check("idle_rd_strobe", oMemReadRequest, 1'b1);
        check("idle_rd_addr", oMemAddr, 16'hC123);
        step();
        cpu_idle();
        check("idle_rd_data", oCpuData, mem_model(16'hC123));
        iCpuAddr = 16'hC200;
        iCpuData = 8'hAA;
        iCpuWe   = 1'b1;
        #1;
        check("idle_wr_strobe", oMemWe, 1'b1);
        check("idle_wr_addr", oMemAddr, 16'hC200);
        check("idle_wr_data", oMemData, 8'hAA);
        step();
        cpu_idle();

        // 2) Full DMA from C000
        cpu_write(16'hFF46, 8'hC0);
        wait_idle(n);
        check("full_busy_cycles", n, 321);
        check_oam(0, 159, 8'h00);
        check_dma_reg(8'hC0);

        // 3) Blocking while busy
        cpu_write(16'hFF46, 8'hC2);
        iCpuAddr = 16'hC000;
        iCpuData = 8'h55;
        iCpuWe   = 1'b1;
        #1;
        check("blk_wr_dropped", oMemWe, 1'b0);
        step();
        cpu_idle();
        iCpuAddr        = 16'h8000;
        iCpuReadRequest = 1'b1;
        #1;
        check("blk_rd_dma_addr", oMemAddr, 16'hC200);
        step();
        cpu_idle();
        check("blk_rd_ff", oCpuData, 8'hFF);
        iCpuAddr = 16'hFF90;
        iCpuData = 8'h3C;
        iCpuWe   = 1'b1;
        #1;
        check("hram_wr_strobe", oMemWe, 1'b1);
        check("hram_wr_addr", oMemAddr, 16'hFF90);
        check("hram_wr_data", oMemData, 8'h3C);
        step();
        cpu_idle();
        wait_idle(n);
        check("blk_done", oDmaBusy, 1'b0);
        check_oam(0, 159, 8'h02);

        // 4) HRAM read collides with the first READ cycle of bytes 0..9
        cpu_write(16'hFF46, 8'hC0);
        for (int b = 0; b < 10; b++) begin
            step();
            iCpuAddr        = 16'hFF85;
            iCpuReadRequest = 1'b1;
            #1;
            check("col_cpu_addr", oMemAddr, 16'hFF85);
            step();
            cpu_idle();
            check("col_cpu_data", oCpuData, mem_model(16'hFF85));
            step();
        end
        step();
        wait_idle(n);
        check("col_busy_cycles", 31 + n, 331);
        check_oam(0, 159, 8'h00);

        // 5) Restart on the WRITE of byte 50, then echo source E1
        cpu_write(16'hFF46, 8'hC0);
        repeat (102) step();
        iCpuAddr = 16'hFF46;
        iCpuData = 8'hD0;
        iCpuWe   = 1'b1;
        #1;
        check("rst_oam_idx", oOamAddr, 8'd50);
        check("restart_no_oam_we", oOamWe, 1'b0);
        step();
        cpu_idle();
        wait_idle(n);
        check("restart_busy_cycles", n, 321);
        check_oam(0, 159, 8'h10);
        cpu_write(16'hFF46, 8'hE1);
        step();
        check("echo_first_addr", oMemAddr, 16'hC100);
        wait_idle(n);
        check_oam(0, 159, 8'h01);

        // 6) Reset at index 80
        cpu_write(16'hFF46, 8'hC0);
        repeat (161) step();
        iReset = 1'b1;
        #1;
        check("mid_rst_busy", oDmaBusy, 1'b0);
        check("mid_rst_oam_we", oOamWe, 1'b0);
        check("mid_rst_mem_rd", oMemReadRequest, 1'b0);
        check("mid_rst_cpu_data", oCpuData, 8'hFF);
        step();
        iReset = 1'b0;
        step();
        check_oam(0, 79, 8'h00);
        check_oam(80, 159, 8'h01);
        check_dma_reg(8'h00);
        cpu_write(16'hFF46, 8'hC0);
        wait_idle(n);
        check("post_rst_busy_cycles", n, 321);
        check_oam(0, 159, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
